// File: rtl/mux_select_unit.sv
// Shared 2:1 and 4:1 data selectors with combinational outputs and en-gated registered copies.
// Optional MUX_PARITY_EN adds out4_par, the registered even parity of out4_q.
module mux_select_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] in0,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic [DWIDTH-1:0] in3,
  input  logic              sel2,
  input  logic [1:0]        sel4,
  input  logic              en,
  output logic [DWIDTH-1:0] out2,
  output logic [DWIDTH-1:0] out4,
  output logic [DWIDTH-1:0] out2_q,
  output logic [DWIDTH-1:0] out4_q
`ifdef MUX_PARITY_EN
  ,
  output logic              out4_par
`endif
);

  // Unknown selects fall to the default branch so X/Z selects drive in0.
  always_comb begin
    out2 = in0;
    case (sel2)
      1'b1:    out2 = in1;
      default: out2 = in0;
    endcase
  end

  always_comb begin
    out4 = in0;
    case (sel4)
      2'b01:   out4 = in1;
      2'b10:   out4 = in2;
      2'b11:   out4 = in3;
      default: out4 = in0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_q <= '0;
      out4_q <= '0;
    end else if (en) begin
      out2_q <= out2;
      out4_q <= out4;
    end
  end

`ifdef MUX_PARITY_EN
  // Parity is taken from the value being loaded so it stays aligned with out4_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out4_par <= 1'b0;
    end else if (en) begin
      out4_par <= ^out4;
    end
  end
`endif

endmodule

// File: tb/tb_mux_select_unit.sv
// Self-checking bench for mux_select_unit: directed steps followed by randomized traffic
// compared against a behavioural selection/pipeline model.
module tb_mux_select_unit;

  localparam int DWIDTH = 32;

  logic              clk;
  logic              rst_n;
  logic [DWIDTH-1:0] in0, in1, in2, in3;
  logic              sel2;
  logic [1:0]        sel4;
  logic              en;
  logic [DWIDTH-1:0] out2, out4, out2_q, out4_q;
`ifdef MUX_PARITY_EN
  logic              out4_par;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [DWIDTH-1:0] exp2_q = '0;
  logic [DWIDTH-1:0] exp4_q = '0;

  mux_select_unit #(.DWIDTH(DWIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .sel2   (sel2),
    .sel4   (sel4),
    .en     (en),
    .out2   (out2),
    .out4   (out4),
    .out2_q (out2_q),
`ifdef MUX_PARITY_EN
    .out4_q (out4_q),
    .out4_par (out4_par)
`else
    .out4_q (out4_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DWIDTH-1:0] ref2();
    logic [DWIDTH-1:0] d [2];
    d[0] = in0;
    d[1] = in1;
    return d[int'(sel2)];
  endfunction

  function automatic logic [DWIDTH-1:0] ref4();
    logic [DWIDTH-1:0] d [4];
    d[0] = in0;
    d[1] = in1;
    d[2] = in2;
    d[3] = in3;
    return d[int'(sel4)];
  endfunction

  task automatic check(input string tag, input logic [DWIDTH-1:0] obs, input logic [DWIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model captures what the flops should sample at the coming edge, then steps past it.
  task automatic tick();
    if (rst_n === 1'b1 && en === 1'b1) begin
      exp2_q = ref2();
      exp4_q = ref4();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_out2_q"}, out2_q, exp2_q);
    check({tag, "_out4_q"}, out4_q, exp4_q);
`ifdef MUX_PARITY_EN
    check({tag, "_par"}, {{(DWIDTH-1){1'b0}}, out4_par},
          {{(DWIDTH-1){1'b0}}, 1'($countones(exp4_q) % 2)});
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel2  = 1'b0;
    sel4  = 2'b00;
    in0   = 32'h0000_0000;
    in1   = 32'h0000_0001;
    in2   = 32'h0000_0010;
    in3   = 32'h0000_0011;
    #1;
    check("rst_out2_q", out2_q, '0);
    check("rst_out4_q", out4_q, '0);

    sel2 = 1'b0; #1; check("mux2_sel0", out2, 32'h0000_0000);
    sel2 = 1'b1; #1; check("mux2_sel1", out2, 32'h0000_0001);

    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      check($sformatf("mux4_sel%0d", s), out4, 32'h0000_0000 | ((s & 1) ? 32'h1 : 32'h0) | ((s & 2) ? 32'h10 : 32'h0));
    end

    sel4 = 2'b10;
    sel2 = 1'b0; #1;
    check("indep_out2_a", out2, 32'h0000_0000);
    check("indep_out4_a", out4, 32'h0000_0010);
    sel2 = 1'b1; #1;
    check("indep_out2_b", out2, 32'h0000_0001);
    check("indep_out4_b", out4, 32'h0000_0010);

    tick();
    check_regs("in_reset");
    check("comb_in_reset", out4, 32'h0000_0010);

    rst_n = 1'b1;
    #1;
    check_regs("post_release");
    en = 1'b1; sel4 = 2'b11;
    tick();
    check("load_out4_q", out4_q, 32'h0000_0011);
    check_regs("load");
    en = 1'b0; sel4 = 2'b00;
    tick();
    tick();
    check("hold_out4_q", out4_q, 32'h0000_0011);
    check_regs("hold");

    in3 = 32'hFFFF_0000; in0 = 32'h1234_5678;
    #1;
    check_regs("no_edge");

    sel4 = 2'b11; in3 = 32'h0000_0011;
    #2;
    rst_n = 1'b0;
    exp2_q = '0;
    exp4_q = '0;
    #1;
    check("async_rst_out4_q", out4_q, 32'h0000_0000);
    check("async_rst_out4", out4, 32'h0000_0011);
    check_regs("async_rst");
    rst_n = 1'b1;

`ifdef MUX_PARITY_EN
    en = 1'b1; sel4 = 2'b11; in3 = 32'h0000_0011;
    tick();
    check("par_even", {{(DWIDTH-1){1'b0}}, out4_par}, '0);
    in3 = 32'h0000_0010;
    tick();
    check("par_odd", {{(DWIDTH-1){1'b0}}, out4_par}, 32'h1);
    #2;
    rst_n = 1'b0;
    exp2_q = '0;
    exp4_q = '0;
    #1;
    check("par_rst", {{(DWIDTH-1){1'b0}}, out4_par}, '0);
    rst_n = 1'b1;
`endif

    for (int i = 0; i < 300; i++) begin
      in0  = $urandom;
      in1  = $urandom;
      in2  = $urandom;
      in3  = $urandom;
      sel2 = 1'($urandom_range(0, 1));
      sel4 = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_out2", out2, ref2());
      check("rnd_out4", out4, ref4());
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        exp2_q = '0;
        exp4_q = '0;
        #1;
        check_regs("rnd_rst");
        check("rnd_rst_out4", out4, ref4());
        rst_n = 1'b1;
      end
      tick();
      check_regs("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_select_unit.md
Name: mux_select_unit

Overview:
- Shared data-selection block for the datapath. It bundles one 2:1 and one 4:1 DWIDTH-bit multiplexer.
- Both multiplexers have zero-latency combinational outputs, used for operand and writeback selection.
- A registered copy of each output, gated by a load enable, is also provided for pipelined consumers.
- Purely structural selection: no arithmetic, no state beyond the output registers.

Parameters:
- DWIDTH, 32, data width of every data input and output.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  DWIDTH  data input 0, shared by both muxes.
- in1  input  DWIDTH  data input 1, shared by both muxes.
- in2  input  DWIDTH  data input 2, 4:1 mux only.
- in3  input  DWIDTH  data input 3, 4:1 mux only.
- sel2  input  1  2:1 select.
- sel4  input  2  4:1 select.
- en  input  1  load enable for the registered outputs.
- out2  output  DWIDTH  combinational 2:1 result.
- out4  output  DWIDTH  combinational 4:1 result.
- out2_q  output  DWIDTH  registered out2.
- out4_q  output  DWIDTH  registered out4.

Behaviour:
- out2 = in0 when sel2=0; out2 = in1 when sel2=1.
- out4 = in0/in1/in2/in3 for sel4 = 00/01/10/11.
- Combinational paths have zero latency and follow any input or select change within the same delta; no clock is involved.
- Both mux decodes are full: every select value maps to an input, no latches, no implied priority.
- A select value that is not 0/1 (X/Z, simulation only) falls to the default branch and drives in0.
- The 2:1 and 4:1 muxes are independent; changing sel2 never affects out4, and vice versa.
- rst_n low, asynchronously and regardless of clk: out2_q and out4_q = 0. This holds while rst_n stays low.
- Reset does not affect out2/out4, which stay combinational throughout reset.
- On rst_n deassertion, the registers hold 0 until the first rising clk with en=1.
- Rising clk with rst_n=1 and en=1: out2_q <= out2 and out4_q <= out4, i.e. one-cycle latency.
- Rising clk with en=0: out2_q and out4_q hold their previous values.
- Reset asserted mid-operation clears the registers immediately; any in-flight value is discarded.
- Input changes with no clk edge alter only out2/out4, never the _q outputs.
- No width conversion: all data ports are exactly DWIDTH bits and values are passed through bit-exact.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Adds output out4_par (1 bit) = even parity (XOR-reduce) of out4_q.
  - It is registered in the same flop stage as out4_q, with the same en gating.
  - It resets to 0 asynchronously on rst_n low.
- Undefined: the out4_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Combinational 2:1 check: in0=0x00000000, in1=0x00000001.
  - sel2=0 -> out2=0x00000000.
  - sel2=1 -> out2=0x00000001.
  - Each checked 1 ns after the change, with no clock.
- Combinational 4:1 sweep: in0..in3 = 0x0, 0x1, 0x10, 0x11.
  - sel4 = 00/01/10/11 -> out4 = 0x00000000/0x00000001/0x00000010/0x00000011, each checked after 1 ns.
- Mux independence: sel4=10 with sel2 toggling 0->1.
  - out4 stays 0x00000010 while out2 follows 0x0 -> 0x1.
- Register load/hold:
  - rst_n=0 -> out2_q=out4_q=0.
  - Release reset, en=1, sel4=11, clock once -> out4_q=0x00000011 one cycle later.
  - en=0, sel4=00, clock twice -> out4_q stays 0x00000011.
- Asynchronous reset mid-operation: out4_q=0x00000011, pull rst_n low between clock edges.
  - out4_q -> 0 immediately.
  - out4 still 0x00000011, since it is combinational.
- MUX_PARITY_EN build:
  - in3=0x00000011, sel4=11, en=1, clock -> out4_par=0 (two set bits).
  - in3=0x00000010, clock -> out4_par=1.
  - Reset -> out4_par=0.
